// File: rtl/datapath.sv
// datapath: single-bus 32-bit CPU datapath with sixteen GPRs, special registers
// (HI, LO, Z, PC, MDR, MAR, IR, Y, InPort, CSE), a priority bus mux and a combinational ALU.
`default_nettype none

module datapath (
  input  logic        clock,
  input  logic        clear,
  input  logic        R0in,  input logic R1in,  input logic R2in,  input logic R3in,
  input  logic        R4in,  input logic R5in,  input logic R6in,  input logic R7in,
  input  logic        R8in,  input logic R9in,  input logic R10in, input logic R11in,
  input  logic        R12in, input logic R13in, input logic R14in, input logic R15in,
  input  logic        R0out,  input logic R1out,  input logic R2out,  input logic R3out,
  input  logic        R4out,  input logic R5out,  input logic R6out,  input logic R7out,
  input  logic        R8out,  input logic R9out,  input logic R10out, input logic R11out,
  input  logic        R12out, input logic R13out, input logic R14out, input logic R15out,
  input  logic        HIin,
  input  logic        LOin,
  input  logic        HIout,
  input  logic        LOout,
  input  logic        Zhighin,
  input  logic        Zlowin,
  input  logic        Zhighout,
  input  logic        Zlowout,
  input  logic        PCin,
  input  logic        PCout,
  input  logic        MDRin,
  input  logic        MDRout,
  input  logic        MARin,
  input  logic        MARout,
  input  logic        InPortin,
  input  logic        InPortout,
  input  logic        CSEin,
  input  logic        CSEout,
  input  logic        IRin,
  input  logic        IRout,
  input  logic [31:0] Mdatain,
  input  logic        MDMuxread,
  input  logic        Yin,
  input  logic        ADD,
  input  logic        SUB,
  input  logic        MUL,
  input  logic        DIV,
  input  logic        AND,
  input  logic        OR,
  input  logic        SHR,
  input  logic        SHRA,
  input  logic        SHL,
  input  logic        ROR,
  input  logic        ROL,
  input  logic        NEG,
  input  logic        NOT,
  input  logic        IncPC,
  input  logic [31:0] InPortdata,
  output logic [31:0] Bus,
  output logic [31:0] MARdata,
  output logic [31:0] IRdata
);

  logic [15:0] gpr_in;
  logic [15:0] gpr_out;
  logic [31:0] gpr [16];
  logic [31:0] hi, lo, zhi, zlo, pc, mdr, mar, ir, y, inport, cse;
  logic [31:0] bus_val;
  logic [63:0] alu;

  assign gpr_in  = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                    R7in, R6in, R5in, R4in, R3in, R2in, R1in, R0in};
  assign gpr_out = {R15out, R14out, R13out, R12out, R11out, R10out, R9out, R8out,
                    R7out, R6out, R5out, R4out, R3out, R2out, R1out, R0out};

  // Lowest-priority source is applied first so later assignments override it.
  always_comb begin
    bus_val = '0;
    if (IRout)     bus_val = ir;
    if (MARout)    bus_val = mar;
    if (CSEout)    bus_val = cse;
    if (InPortout) bus_val = inport;
    if (MDRout)    bus_val = mdr;
    if (PCout)     bus_val = pc;
    if (Zlowout)   bus_val = zlo;
    if (Zhighout)  bus_val = zhi;
    if (LOout)     bus_val = lo;
    if (HIout)     bus_val = hi;
    for (int i = 15; i >= 0; i--) begin
      if (gpr_out[i]) bus_val = gpr[i];
    end
  end

  assign Bus     = clear ? bus_val : 32'd0;
  assign MARdata = mar;
  assign IRdata  = ir;

  logic [4:0]         shamt;
  logic [63:0]        prod;
  logic [63:0]        rot_r;
  logic [63:0]        rot_l;
  logic signed [31:0] sa;
  logic signed [31:0] sb;
  logic [31:0]        quot;
  logic [31:0]        rem;

  assign shamt = bus_val[4:0];
  assign prod  = {{32{y[31]}}, y} * {{32{bus_val[31]}}, bus_val};
  assign rot_r = {y, y} >> shamt;
  assign rot_l = {y, y} << shamt;
  assign sa    = y;
  assign sb    = bus_val;

  // Divide by zero and the single overflowing quotient are pinned explicitly.
  always_comb begin
    quot = '0;
    rem  = '0;
    if (sb == 32'sd0) begin
      quot = 32'hFFFF_FFFF;
      rem  = y;
    end else if (sa == 32'sh8000_0000 && sb == -32'sd1) begin
      quot = 32'h8000_0000;
      rem  = 32'd0;
    end else begin
      quot = sa / sb;
      rem  = sa % sb;
    end
  end

  always_comb begin
    alu = {32'd0, bus_val};
    if      (IncPC) alu = {32'd0, bus_val + 32'd1};
    else if (ADD)   alu = {32'd0, y + bus_val};
    else if (SUB)   alu = {32'd0, y - bus_val};
    else if (MUL)   alu = prod;
    else if (DIV)   alu = {rem, quot};
    else if (AND)   alu = {32'd0, y & bus_val};
    else if (OR)    alu = {32'd0, y | bus_val};
    else if (SHR)   alu = {32'd0, y >> shamt};
    else if (SHRA)  alu = {32'd0, 32'($signed(y) >>> shamt)};
    else if (SHL)   alu = {32'd0, y << shamt};
    else if (ROR)   alu = {32'd0, rot_r[31:0]};
    else if (ROL)   alu = {32'd0, rot_l[63:32]};
    else if (NEG)   alu = {32'd0, 32'd0 - bus_val};
    else if (NOT)   alu = {32'd0, ~bus_val};
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < 16; i++) gpr[i] <= '0;
      hi     <= '0;
      lo     <= '0;
      zhi    <= '0;
      zlo    <= '0;
      pc     <= '0;
      mdr    <= '0;
      mar    <= '0;
      ir     <= '0;
      y      <= '0;
      inport <= '0;
      cse    <= '0;
    end else begin
      for (int i = 0; i < 16; i++) begin
        if (gpr_in[i]) gpr[i] <= bus_val;
      end
      if (HIin)     hi     <= bus_val;
      if (LOin)     lo     <= bus_val;
      if (Zhighin)  zhi    <= alu[63:32];
      if (Zlowin)   zlo    <= alu[31:0];
      if (PCin)     pc     <= bus_val;
      if (MDRin)    mdr    <= MDMuxread ? Mdatain : bus_val;
      if (MARin)    mar    <= bus_val;
      if (IRin)     ir     <= bus_val;
      if (Yin)      y      <= bus_val;
      if (InPortin) inport <= InPortdata;
      if (CSEin)    cse    <= {{13{ir[18]}}, ir[18:0]};
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_datapath.sv
// tb_datapath: directed vector bench for the single-bus CPU datapath.
`default_nettype none

module tb_datapath;

  logic        clock = 1'b0;
  logic        clear;
  logic [15:0] rin, rout;
  logic [13:0] op;
  logic HIin, LOin, HIout, LOout, Zhighin, Zlowin, Zhighout, Zlowout;
  logic PCin, PCout, MDRin, MDRout, MARin, MARout, InPortin, InPortout;
  logic CSEin, CSEout, IRin, IRout, MDMuxread, Yin;
  logic [31:0] Mdatain, InPortdata;
  logic [31:0] Bus, MARdata, IRdata;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  datapath dut (
    .clock(clock), .clear(clear),
    .R0in(rin[0]), .R1in(rin[1]), .R2in(rin[2]), .R3in(rin[3]),
    .R4in(rin[4]), .R5in(rin[5]), .R6in(rin[6]), .R7in(rin[7]),
    .R8in(rin[8]), .R9in(rin[9]), .R10in(rin[10]), .R11in(rin[11]),
    .R12in(rin[12]), .R13in(rin[13]), .R14in(rin[14]), .R15in(rin[15]),
    .R0out(rout[0]), .R1out(rout[1]), .R2out(rout[2]), .R3out(rout[3]),
    .R4out(rout[4]), .R5out(rout[5]), .R6out(rout[6]), .R7out(rout[7]),
    .R8out(rout[8]), .R9out(rout[9]), .R10out(rout[10]), .R11out(rout[11]),
    .R12out(rout[12]), .R13out(rout[13]), .R14out(rout[14]), .R15out(rout[15]),
    .HIin(HIin), .LOin(LOin), .HIout(HIout), .LOout(LOout),
    .Zhighin(Zhighin), .Zlowin(Zlowin), .Zhighout(Zhighout), .Zlowout(Zlowout),
    .PCin(PCin), .PCout(PCout), .MDRin(MDRin), .MDRout(MDRout),
    .MARin(MARin), .MARout(MARout), .InPortin(InPortin), .InPortout(InPortout),
    .CSEin(CSEin), .CSEout(CSEout), .IRin(IRin), .IRout(IRout),
    .Mdatain(Mdatain), .MDMuxread(MDMuxread), .Yin(Yin),
    .ADD(op[1]), .SUB(op[2]), .MUL(op[3]), .DIV(op[4]), .AND(op[5]), .OR(op[6]),
    .SHR(op[7]), .SHRA(op[8]), .SHL(op[9]), .ROR(op[10]), .ROL(op[11]),
    .NEG(op[12]), .NOT(op[13]), .IncPC(op[0]),
    .InPortdata(InPortdata),
    .Bus(Bus), .MARdata(MARdata), .IRdata(IRdata)
  );

  localparam int O_INC = 0, O_ADD = 1, O_SUB = 2, O_MUL = 3, O_DIV = 4, O_AND = 5,
                 O_OR = 6, O_SHR = 7, O_SHRA = 8, O_SHL = 9, O_ROR = 10, O_ROL = 11,
                 O_NEG = 12, O_NOT = 13;

  typedef struct {
    string       name;
    logic [13:0] op;
    logic [31:0] y;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
  } vec_t;

  vec_t vt[18];

  function automatic logic [13:0] opb(input int k);
    logic [13:0] m;
    m = '0;
    m[k] = 1'b1;
    return m;
  endfunction

  task automatic clr_ctl();
    rin = '0; rout = '0; op = '0;
    HIin = 0; LOin = 0; HIout = 0; LOout = 0;
    Zhighin = 0; Zlowin = 0; Zhighout = 0; Zlowout = 0;
    PCin = 0; PCout = 0; MDRin = 0; MDRout = 0; MARin = 0; MARout = 0;
    InPortin = 0; InPortout = 0; CSEin = 0; CSEout = 0; IRin = 0; IRout = 0;
    MDMuxread = 0; Yin = 0;
  endtask

  // Controls set just after a falling edge are held across the next rising edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
    clr_ctl();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic load_mdr(input logic [31:0] v);
    Mdatain = v; MDMuxread = 1; MDRin = 1;
    tick();
  endtask

  task automatic run_vec(input vec_t v);
    load_mdr(v.y);
    MDRout = 1; Yin = 1;
    tick();
    load_mdr(v.b);
    MDRout = 1; op = v.op; Zlowin = 1; Zhighin = 1;
    tick();
    Zlowout = 1; #1;
    check({v.name, ".lo"}, Bus, v.lo);
    clr_ctl();
    Zhighout = 1; #1;
    check({v.name, ".hi"}, Bus, v.hi);
    clr_ctl();
  endtask

  initial begin
    vt[0]  = '{"SHR",   opb(O_SHR),  32'h80000001, 32'd4, 32'h08000000, 32'h0};
    vt[1]  = '{"SHRA",  opb(O_SHRA), 32'h80000001, 32'd4, 32'hF8000000, 32'h0};
    vt[2]  = '{"SHL",   opb(O_SHL),  32'h80000001, 32'd4, 32'h00000010, 32'h0};
    vt[3]  = '{"ROR",   opb(O_ROR),  32'h80000001, 32'd4, 32'h18000000, 32'h0};
    vt[4]  = '{"ROL",   opb(O_ROL),  32'h80000001, 32'd4, 32'h00000018, 32'h0};
    vt[5]  = '{"MUL",   opb(O_MUL),  32'hFFFFFFFE, 32'd3, 32'hFFFFFFFA, 32'hFFFFFFFF};
    vt[6]  = '{"DIV",   opb(O_DIV),  32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h1};
    vt[7]  = '{"DIV0",  opb(O_DIV),  32'd7, 32'd0, 32'hFFFFFFFF, 32'h7};
    vt[8]  = '{"DIVNEG",opb(O_DIV),  32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF};
    vt[9]  = '{"ADD",   opb(O_ADD),  32'd5, 32'd7, 32'd12, 32'h0};
    vt[10] = '{"SUB",   opb(O_SUB),  32'd3, 32'd5, 32'hFFFFFFFE, 32'h0};
    vt[11] = '{"AND",   opb(O_AND),  32'hF0F0F0F0, 32'h0FF00FF0, 32'h00F000F0, 32'h0};
    vt[12] = '{"OR",    opb(O_OR),   32'hF0F0F0F0, 32'h0FF00FF0, 32'hFFF0FFF0, 32'h0};
    vt[13] = '{"NEG",   opb(O_NEG),  32'd9, 32'd1, 32'hFFFFFFFF, 32'h0};
    vt[14] = '{"NOT",   opb(O_NOT),  32'd9, 32'h0000FFFF, 32'hFFFF0000, 32'h0};
    vt[15] = '{"INC",   opb(O_INC),  32'd9, 32'hFFFFFFFF, 32'h0, 32'h0};
    vt[16] = '{"PASS",  14'd0,       32'd9, 32'h12345678, 32'h12345678, 32'h0};
    vt[17] = '{"PRIO",  opb(O_INC) | opb(O_ADD), 32'd5, 32'd7, 32'd8, 32'h0};

    clr_ctl();
    Mdatain = '0; InPortdata = '0;
    clear = 0;
    repeat (2) @(negedge clock);
    rout[0] = 1; #1;
    check("reset.bus", Bus, 32'h0);
    check("reset.mar", MARdata, 32'h0);
    check("reset.ir", IRdata, 32'h0);
    clr_ctl();
    clear = 1;

    // Instruction fetch T0..T2
    PCout = 1; MARin = 1; op[O_INC] = 1; Zlowin = 1; tick();
    Zlowout = 1; PCin = 1; MDMuxread = 1; MDRin = 1; Mdatain = 32'h48918000; tick();
    MDRout = 1; IRin = 1; tick();
    check("fetch.mar", MARdata, 32'h0);
    check("fetch.ir", IRdata, 32'h48918000);
    PCout = 1; #1; check("fetch.pc", Bus, 32'h1); clr_ctl();
    CSEin = 1; tick();
    CSEout = 1; #1; check("cse.pos", Bus, 32'h00018000); clr_ctl();

    // Register-register ROL, T3..T5
    load_mdr(32'hFFFF3000); MDRout = 1; rin[2] = 1; tick();
    load_mdr(32'h10);       MDRout = 1; rin[3] = 1; tick();
    rout[2] = 1; Yin = 1; tick();
    rout[3] = 1; op[O_ROL] = 1; Zlowin = 1; tick();
    Zlowout = 1; rin[1] = 1; tick();
    rout[1] = 1; #1; check("rol.r1", Bus, 32'h3000FFFF); clr_ctl();

    foreach (vt[i]) run_vec(vt[i]);

    // Bus priority
    load_mdr(32'd5); MDRout = 1; rin[5] = 1; tick();
    load_mdr(32'd9); MDRout = 1; PCin = 1; tick();
    rout[5] = 1; PCout = 1; #1; check("prio.r5_pc", Bus, 32'd5); clr_ctl();
    PCout = 1; #1; check("prio.pc", Bus, 32'd9); clr_ctl();
    #1; check("prio.none", Bus, 32'd0);
    InPortdata = 32'hCAFEBABE; InPortin = 1; tick();
    InPortout = 1; CSEout = 1; #1; check("prio.inport_cse", Bus, 32'hCAFEBABE); clr_ctl();
    MDRout = 1; InPortout = 1; #1; check("prio.mdr_inport", Bus, 32'd9); clr_ctl();

    // Negative sign extension into CSE
    load_mdr(32'h00040005); MDRout = 1; IRin = 1; tick();
    CSEin = 1; tick();
    CSEout = 1; #1; check("cse.neg", Bus, 32'hFFFC0005); clr_ctl();

    // Same register as bus source and load target
    load_mdr(32'd41); MDRout = 1; Zlowin = 1; tick();
    Zlowout = 1; Zlowin = 1; op[O_INC] = 1; tick();
    Zlowout = 1; #1; check("self.zlo", Bus, 32'd42); clr_ctl();

    // Reset dropped in the middle of T4
    load_mdr(32'h10); MDRout = 1; MARin = 1; tick();
    rout[2] = 1; Yin = 1; tick();
    rout[3] = 1; op[O_ROL] = 1; Zlowin = 1;
    #2 clear = 0;
    #1;
    check("mreset.bus", Bus, 32'h0);
    check("mreset.mar", MARdata, 32'h0);
    check("mreset.ir", IRdata, 32'h0);
    @(posedge clock);
    @(negedge clock);
    clr_ctl();
    clear = 1;
    Zlowout = 1; #1; check("mreset.zlo", Bus, 32'h0); clr_ctl();
    rout[2] = 1; #1; check("mreset.r2", Bus, 32'h0); clr_ctl();
    PCout = 1; #1; check("mreset.pc", Bus, 32'h0); clr_ctl();
    load_mdr(32'h11); MDRout = 1; op[O_ADD] = 1; Zlowin = 1; tick();
    Zlowout = 1; #1; check("mreset.y", Bus, 32'h11); clr_ctl();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
